// File: rtl/cpu_types_pkg.sv
// Shared types for the MEM stage: word, memory opcodes, FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package cpu_types_pkg;

    localparam int WORD_W   = 32;  // data/address width
    localparam int LINK_LSB = 2;   // address LSBs ignored in link compares

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ALU = 3'd1,
        OP_LW  = 3'd2,
        OP_SW  = 3'd3,
        OP_LL  = 3'd4,
        OP_SC  = 3'd5
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Word-granular address equality: bits below LINK_LSB are don't-care.
    function automatic logic addr_match(input word_t a, input word_t b);
        return ((a ^ b) >> LINK_LSB) == '0;
    endfunction

endpackage

// File: rtl/mem_stage_ll_sc_link.sv
// LL/SC link register: set by LL, cleared by SC, own SW or snoop invalidate.
// Latency: set/clear visible the cycle after the causing event.
// Backpressure: none; events are single-cycle strobes.
module ll_sc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ll_done_i,
    input  logic  sc_done_i,
    input  logic  sw_done_i,
    input  word_t req_addr_i,
    input  logic  snoop_inv_i,
    input  word_t snoop_addr_i,
    input  word_t query_addr_i,
    output logic  link_valid_o,
    output logic  link_match_o
);

    logic  valid_q, valid_d;
    word_t addr_q, addr_d;

    // Next link state; the snoop compares against the address the link will
    // hold, so an LL and a snoop to the same word in one cycle leaves it clear.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (ll_done_i) begin
            valid_d = 1'b1;
            addr_d  = req_addr_i;
        end
        if (sc_done_i) begin
            valid_d = 1'b0;
        end
        if (sw_done_i && addr_match(req_addr_i, addr_q)) begin
            valid_d = 1'b0;
        end
        if (snoop_inv_i && addr_match(snoop_addr_i, addr_d)) begin
            valid_d = 1'b0;
        end
    end

    // Link state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign link_valid_o = valid_q;
    assign link_match_o = valid_q && addr_match(query_addr_i, addr_q);

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives dcache LW/SW/LL/SC requests and owns the LL/SC link.
// Latency: request issued combinationally in the EX/MEM cycle; done on dhit.
// Backpressure: mem_stall high and memwb_en low while a request awaits dhit.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic    CLK,
    input  logic    nRST,
    input  logic    ex_valid,
    input  opcode_t ex_opcode,
    input  word_t   ex_addr,
    input  word_t   ex_store,
    input  logic    ex_halt,
    input  logic    dhit,
    input  word_t   dmemload,
    input  logic    snoop_inv,
    input  word_t   snoop_addr,
    output logic    dmemREN,
    output logic    dmemWEN,
    output word_t   dmemaddr,
    output word_t   dmemstore,
    output logic    mem_stall,
    output logic    memwb_en,
    output word_t   wb_dload,
    output logic    halt_o
);

    mem_state_t state_q, state_d;
    opcode_t    op_q, op_d;
    word_t      addr_q, addr_d;
    word_t      data_q, data_d;
    logic       halt_q;

    opcode_t    cur_op;
    logic       cur_ren, cur_wen;
    word_t      cur_addr, cur_data;
    logic       link_ok, new_ren, new_wen, issue, done;

    assign new_ren = (ex_opcode == OP_LW) || (ex_opcode == OP_LL);
    // A failing SC never reaches the cache: it completes in zero cycles.
    assign new_wen = (ex_opcode == OP_SW) || ((ex_opcode == OP_SC) && link_ok);
    // nRST gates issue so a not-yet-cleared EX/MEM latch cannot raise a request.
    assign issue   = nRST && ex_valid && !halt_q && (new_ren || new_wen);

    // FSM next state and current request; WAIT replays the captured request.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cur_op   = OP_NOP;
        cur_ren  = 1'b0;
        cur_wen  = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    cur_op   = ex_opcode;
                    cur_ren  = new_ren;
                    cur_wen  = new_wen;
                    cur_addr = ex_addr;
                    cur_data = new_wen ? ex_store : '0;
                    if (!dhit) begin
                        state_d = WAIT;
                        op_d    = ex_opcode;
                        addr_d  = ex_addr;
                        data_d  = new_wen ? ex_store : '0;
                    end
                end
            end
            WAIT: begin
                cur_op   = op_q;
                cur_ren  = (op_q == OP_LW) || (op_q == OP_LL);
                cur_wen  = (op_q == OP_SW) || (op_q == OP_SC);
                cur_addr = addr_q;
                cur_data = data_q;
                if (dhit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, captured request and sticky halt.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            data_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            halt_q  <= halt_q || (ex_valid && ex_halt);
        end
    end

    assign done      = (cur_ren || cur_wen) && dhit;
    assign dmemREN   = cur_ren;
    assign dmemWEN   = cur_wen;
    assign dmemaddr  = cur_addr;
    assign dmemstore = cur_data;
    assign mem_stall = (cur_ren || cur_wen) && !dhit;
    assign memwb_en  = !mem_stall;
    assign halt_o    = halt_q;

    // Writeback data: load data or SC success flag, only in the dhit cycle.
    always_comb begin
        wb_dload = '0;
        if (done) begin
            if (cur_ren) begin
                wb_dload = dmemload;
            end else if (cur_op == OP_SC) begin
                wb_dload = word_t'(1);
            end
        end
    end

    ll_sc_link u_link (
        .CLK          (CLK),
        .nRST         (nRST),
        .ll_done_i    (done && (cur_op == OP_LL)),
        .sc_done_i    (done && (cur_op == OP_SC)),
        .sw_done_i    (done && (cur_op == OP_SW)),
        .req_addr_i   (cur_addr),
        .snoop_inv_i  (snoop_inv),
        .snoop_addr_i (snoop_addr),
        .query_addr_i (ex_addr),
        .link_valid_o (),
        .link_match_o (link_ok)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, hand sequences, random vs model.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: the model tracks the pending request across stalled cycles.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic    CLK = 1'b0;
    logic    nRST;
    logic    ex_valid, ex_halt, dhit, snoop_inv;
    opcode_t ex_opcode;
    word_t   ex_addr, ex_store, dmemload, snoop_addr;
    logic    dmemREN, dmemWEN, mem_stall, memwb_en, halt_o;
    word_t   dmemaddr, dmemstore, wb_dload;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_addr(ex_addr), .ex_store(ex_store), .ex_halt(ex_halt), .dhit(dhit),
        .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .memwb_en(memwb_en),
        .wb_dload(wb_dload), .halt_o(halt_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic setin(input logic v, input opcode_t op, input word_t a, input word_t st,
                         input logic h, input logic dh, input word_t ld,
                         input logic sn, input word_t sa);
        ex_valid = v; ex_opcode = op; ex_addr = a; ex_store = st; ex_halt = h;
        dhit = dh; dmemload = ld; snoop_inv = sn; snoop_addr = sa;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic v; opcode_t op; word_t addr; word_t store; logic dh; word_t ld;
        logic sn; word_t sa;
        logic e_ren; logic e_wen; word_t e_addr; word_t e_store; logic e_stall; word_t e_wb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic v, input opcode_t op, input word_t a, input word_t st,
                                input logic dh, input word_t ld, input logic sn, input word_t sa,
                                input logic er, input logic ew, input word_t ea, input word_t es,
                                input logic estl, input word_t ewb);
        vec_t r;
        r.v = v; r.op = op; r.addr = a; r.store = st; r.dh = dh; r.ld = ld; r.sn = sn; r.sa = sa;
        r.e_ren = er; r.e_wen = ew; r.e_addr = ea; r.e_store = es; r.e_stall = estl; r.e_wb = ewb;
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic    m_pend, m_lv, m_halt;
    opcode_t m_op;
    word_t   m_addr, m_data, m_la;

    function automatic logic same_word(input word_t a, input word_t b);
        return a[31:2] == b[31:2];
    endfunction

    task automatic model_reset();
        m_pend = 1'b0; m_lv = 1'b0; m_halt = 1'b0; m_op = OP_NOP;
        m_addr = '0; m_data = '0; m_la = '0;
    endtask

    // Compare this cycle's outputs against the model, then advance the model.
    task automatic model_cycle();
        logic req, isld;
        opcode_t rop;
        word_t rad, rdat, ewb;
        req = 1'b0; rop = OP_NOP; rad = '0; rdat = '0;
        if (!nRST) begin
            model_reset();
        end else if (m_pend) begin
            req = 1'b1; rop = m_op; rad = m_addr; rdat = m_data;
        end else if (ex_valid && !m_halt &&
                     (ex_opcode inside {OP_LW, OP_SW, OP_LL, OP_SC})) begin
            req = !(ex_opcode == OP_SC && !(m_lv && same_word(m_la, ex_addr)));
            rop = ex_opcode; rad = ex_addr; rdat = ex_store;
        end
        isld = (rop == OP_LW) || (rop == OP_LL);
        ewb  = '0;
        if (req && dhit) ewb = isld ? dmemload : ((rop == OP_SC) ? 32'd1 : 32'd0);
        chk1("rnd_ren", dmemREN, req && isld);
        chk1("rnd_wen", dmemWEN, req && !isld);
        chk1("rnd_stall", mem_stall, req && !dhit);
        chk1("rnd_memwb", memwb_en, !(req && !dhit));
        chk32("rnd_wb", wb_dload, ewb);
        chk1("rnd_halt", halt_o, m_halt);
        if (req) chk32("rnd_addr", dmemaddr, rad);
        if (req && !isld) chk32("rnd_store", dmemstore, rdat);
        if (nRST) begin
            if (req && dhit) begin
                m_pend = 1'b0;
                if (rop == OP_LL) begin m_lv = 1'b1; m_la = rad; end
                if (rop == OP_SC) m_lv = 1'b0;
                if (rop == OP_SW && same_word(m_la, rad)) m_lv = 1'b0;
            end else if (req) begin
                m_pend = 1'b1; m_op = rop; m_addr = rad; m_data = rdat;
            end
            if (snoop_inv && same_word(snoop_addr, m_la)) m_lv = 1'b0;
            if (ex_valid && ex_halt) m_halt = 1'b1;
        end
    endtask

    opcode_t ops[6]  = '{OP_NOP, OP_ALU, OP_LW, OP_SW, OP_LL, OP_SC};
    word_t   pool[5] = '{32'h100, 32'h104, 32'h102, 32'h200, 32'h300};

    initial begin
        // ---------------- reset state ----------------
        nRST = 1'b0;
        setin(1'b0, OP_NOP, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
        #12;
        chk1("rst_ren", dmemREN, 1'b0);
        chk1("rst_wen", dmemWEN, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk1("rst_memwb", memwb_en, 1'b1);
        chk32("rst_wb", wb_dload, 32'h0);
        chk32("rst_addr", dmemaddr, 32'h0);
        chk1("rst_halt", halt_o, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;

        //            v  op      addr     store    dh  ld        sn  sa        ren wen eaddr    estore  stl  ewb
        vt.push_back(mk(0, OP_NOP, 32'h0,   32'h0,   0, 32'h0,    0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0));
        vt.push_back(mk(1, OP_LW,  32'h40,  32'h0,   1, 32'hCAFE, 0, 32'h0,   1, 0, 32'h40,  32'h0,   0, 32'hCAFE));
        vt.push_back(mk(1, OP_SW,  32'h80,  32'h1234,0, 32'h0,    0, 32'h0,   0, 1, 32'h80,  32'h1234,1, 32'h0));
        vt.push_back(mk(1, OP_SW,  32'h80,  32'h1234,0, 32'h0,    0, 32'h0,   0, 1, 32'h80,  32'h1234,1, 32'h0));
        vt.push_back(mk(1, OP_SW,  32'h80,  32'h1234,0, 32'h0,    0, 32'h0,   0, 1, 32'h80,  32'h1234,1, 32'h0));
        vt.push_back(mk(1, OP_SW,  32'h80,  32'h1234,1, 32'h0,    0, 32'h0,   0, 1, 32'h80,  32'h1234,0, 32'h0));
        vt.push_back(mk(1, OP_LL,  32'h100, 32'h0,   1, 32'h55,   0, 32'h0,   1, 0, 32'h100, 32'h0,   0, 32'h55));
        vt.push_back(mk(1, OP_SC,  32'h100, 32'hAA,  1, 32'h0,    0, 32'h0,   0, 1, 32'h100, 32'hAA,  0, 32'h1));
        vt.push_back(mk(1, OP_SC,  32'h100, 32'hAA,  1, 32'h0,    0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0));
        vt.push_back(mk(1, OP_LL,  32'h100, 32'h0,   1, 32'h7,    0, 32'h0,   1, 0, 32'h100, 32'h0,   0, 32'h7));
        vt.push_back(mk(0, OP_NOP, 32'h0,   32'h0,   0, 32'h0,    1, 32'h102, 0, 0, 32'h0,   32'h0,   0, 32'h0));
        vt.push_back(mk(1, OP_SC,  32'h100, 32'hBB,  1, 32'h0,    0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0));
        vt.push_back(mk(1, OP_LL,  32'h100, 32'h0,   1, 32'h9,    1, 32'h100, 1, 0, 32'h100, 32'h0,   0, 32'h9));
        vt.push_back(mk(1, OP_SC,  32'h100, 32'hCC,  1, 32'h0,    0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0));
        vt.push_back(mk(1, OP_LL,  32'h104, 32'h0,   0, 32'h0,    0, 32'h0,   1, 0, 32'h104, 32'h0,   1, 32'h0));
        vt.push_back(mk(1, OP_LW,  32'h300, 32'h0,   1, 32'h11,   0, 32'h0,   1, 0, 32'h104, 32'h0,   0, 32'h11));
        vt.push_back(mk(1, OP_SC,  32'h104, 32'hAA,  0, 32'h0,    0, 32'h0,   0, 1, 32'h104, 32'hAA,  1, 32'h0));
        vt.push_back(mk(1, OP_SC,  32'h104, 32'hAA,  1, 32'h0,    1, 32'h104, 0, 1, 32'h104, 32'hAA,  0, 32'h1));
        vt.push_back(mk(1, OP_SC,  32'h104, 32'hAA,  1, 32'h0,    0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0));
        vt.push_back(mk(1, OP_LL,  32'h200, 32'h0,   1, 32'h3,    0, 32'h0,   1, 0, 32'h200, 32'h0,   0, 32'h3));
        vt.push_back(mk(1, OP_SW,  32'h200, 32'h5,   1, 32'h0,    0, 32'h0,   0, 1, 32'h200, 32'h5,   0, 32'h0));
        vt.push_back(mk(1, OP_SC,  32'h200, 32'h6,   1, 32'h0,    0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0));
        vt.push_back(mk(1, OP_ALU, 32'h44,  32'h0,   1, 32'h77,   0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0));

        foreach (vt[i]) begin
            @(posedge CLK); #1;
            setin(vt[i].v, vt[i].op, vt[i].addr, vt[i].store, 1'b0, vt[i].dh, vt[i].ld,
                  vt[i].sn, vt[i].sa);
            @(negedge CLK);
            chk1($sformatf("v%0d_ren", i), dmemREN, vt[i].e_ren);
            chk1($sformatf("v%0d_wen", i), dmemWEN, vt[i].e_wen);
            chk1($sformatf("v%0d_stall", i), mem_stall, vt[i].e_stall);
            chk1($sformatf("v%0d_memwb", i), memwb_en, !vt[i].e_stall);
            chk32($sformatf("v%0d_wb", i), wb_dload, vt[i].e_wb);
            if (vt[i].e_ren || vt[i].e_wen) chk32($sformatf("v%0d_addr", i), dmemaddr, vt[i].e_addr);
            if (vt[i].e_wen) chk32($sformatf("v%0d_store", i), dmemstore, vt[i].e_store);
        end

        // ---------------- reset in the middle of WAIT ----------------
        @(posedge CLK); #1;
        setin(1'b1, OP_LL, 32'h100, '0, 1'b0, 1'b1, 32'h1, 1'b0, '0);
        @(posedge CLK); #1;
        setin(1'b1, OP_LW, 32'h40, '0, 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge CLK);
        chk1("wait_stall", mem_stall, 1'b1);
        chk1("wait_ren", dmemREN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        chk1("midrst_ren", dmemREN, 1'b0);
        chk1("midrst_wen", dmemWEN, 1'b0);
        chk1("midrst_stall", mem_stall, 1'b0);
        chk1("midrst_memwb", memwb_en, 1'b1);
        @(posedge CLK); #1;
        nRST = 1'b1;
        setin(1'b1, OP_SC, 32'h100, 32'h9, 1'b0, 1'b1, '0, 1'b0, '0);
        @(negedge CLK);
        chk1("postrst_sc_wen", dmemWEN, 1'b0);
        chk1("postrst_sc_stall", mem_stall, 1'b0);
        chk32("postrst_sc_wb", wb_dload, 32'h0);

        // ---------------- sticky halt ----------------
        @(posedge CLK); #1;
        setin(1'b1, OP_NOP, '0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
        @(negedge CLK);
        chk1("halt_pre", halt_o, 1'b0);
        @(posedge CLK); #1;
        setin(1'b1, OP_LW, 32'h40, '0, 1'b0, 1'b1, 32'hCAFE, 1'b0, '0);
        @(negedge CLK);
        chk1("halt_set", halt_o, 1'b1);
        chk1("halt_lw_ren", dmemREN, 1'b0);
        chk32("halt_lw_wb", wb_dload, 32'h0);
        chk1("halt_lw_memwb", memwb_en, 1'b1);
        @(posedge CLK); #1;
        setin(1'b1, OP_SW, 32'h80, 32'h1, 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge CLK);
        chk1("halt_sticky", halt_o, 1'b1);
        chk1("halt_sw_wen", dmemWEN, 1'b0);
        chk1("halt_sw_stall", mem_stall, 1'b0);

        // ---------------- randomized run against the model ----------------
        @(posedge CLK); #1;
        nRST = 1'b0;
        setin(1'b0, OP_NOP, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
        model_reset();
        @(posedge CLK); #1;
        nRST = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            nRST = ($urandom_range(0, 199) != 0);
            setin(($urandom % 4) != 0, ops[$urandom_range(0, 5)], pool[$urandom_range(0, 4)],
                  $urandom, $urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 4) == 0, pool[$urandom_range(0, 4)]);
            @(negedge CLK);
            model_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
